// File: rtl/portal_echo_user.sv
// Portal echo user: accepts one request message (header + payload), buffers up to DEPTH
// payload words, then returns an indication with the header flagged and the payload inverted.
module portal_echo_user #(
   parameter int DEPTH = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        write_enq__ENA,
   input  logic [31:0] write_enq_v,
   input  logic        write_enq_last,
   output logic        write_enq__RDY,
   output logic        read_enq__ENA,
   output logic [31:0] read_enq_v,
   output logic        read_enq_last,
   input  logic        read_enq__RDY,
   output logic [7:0]  errCount
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RECV      = 2'd1,
      S_SEND_HDR  = 2'd2,
      S_SEND_DATA = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] method_q, method_d;
   logic [15:0] len_q, len_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic        ovf_q, ovf_d;
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic [7:0]  err_q, err_d;
   logic        wr_rdy_q, wr_rdy_d;
   logic        rd_ena_q, rd_ena_d;
   logic [31:0] rd_v_q, rd_v_d;
   logic        rd_last_q, rd_last_d;

   logic [31:0] buf_q [DEPTH];
   logic        buf_we_s;
   logic        to_hdr_s;
   logic        wr_xfer_s;
   logic        rd_xfer_s;

   assign wr_xfer_s = write_enq__ENA & wr_rdy_q;
   assign rd_xfer_s = rd_ena_q & read_enq__RDY;

   // Message sequencing: capture, store/discard payload, then step through the echo beats.
   always_comb begin
      state_d  = state_q;
      method_d = method_q;
      len_d    = len_q;
      rx_cnt_d = rx_cnt_q;
      ovf_d    = ovf_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      err_d    = err_q;
      buf_we_s = 1'b0;
      to_hdr_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_xfer_s) begin
               method_d = write_enq_v[31:16];
               len_d    = write_enq_v[15:0];
               wptr_d   = '0;
               rx_cnt_d = 16'd0;
               ovf_d    = 1'b0;
               if (write_enq_last) begin
                  state_d  = S_SEND_HDR;
                  to_hdr_s = 1'b1;
               end else begin
                  state_d = S_RECV;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RECV: begin
            if (wr_xfer_s) begin
               if (rx_cnt_q != 16'hFFFF) begin
                  rx_cnt_d = rx_cnt_q + 16'd1;
               end else begin
                  rx_cnt_d = rx_cnt_q;
               end
               if (wptr_q < DEPTH_W) begin
                  buf_we_s = 1'b1;
                  wptr_d   = wptr_q + ONE_W;
               end else begin
                  ovf_d = 1'b1;
               end
               if (write_enq_last) begin
                  state_d  = S_SEND_HDR;
                  to_hdr_s = 1'b1;
               end else begin
                  state_d = S_RECV;
               end
            end else begin
               state_d = S_RECV;
            end
         end
         S_SEND_HDR: begin
            if (rd_xfer_s) begin
               if (wptr_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  rptr_d  = '0;
                  state_d = S_SEND_DATA;
               end
            end else begin
               state_d = S_SEND_HDR;
            end
         end
         S_SEND_DATA: begin
            if (rd_xfer_s) begin
               rptr_d = rptr_q + ONE_W;
               if (rd_last_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_SEND_DATA;
               end
            end else begin
               state_d = S_SEND_DATA;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Judged on the post-transfer counters so the final request word is included.
      if (to_hdr_s && (ovf_d || (rx_cnt_d != len_d)) && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end else begin
         err_d = err_q;
      end
   end

   // Outputs are precomputed from the next state so they leave the block registered.
   always_comb begin
      wr_rdy_d  = 1'b0;
      rd_ena_d  = 1'b0;
      rd_v_d    = 32'd0;
      rd_last_d = 1'b0;
      case (state_d)
         S_IDLE, S_RECV: begin
            wr_rdy_d = 1'b1;
         end
         S_SEND_HDR: begin
            rd_ena_d  = 1'b1;
            rd_v_d    = {method_d | 16'h8000, 16'(wptr_d)};
            rd_last_d = (wptr_d == '0);
         end
         S_SEND_DATA: begin
            rd_ena_d  = 1'b1;
            rd_v_d    = ~buf_q[rptr_d[AW-1:0]];
            rd_last_d = (rptr_d == (wptr_d - ONE_W));
         end
         default: begin
            wr_rdy_d = 1'b0;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= S_IDLE;
         method_q  <= 16'd0;
         len_q     <= 16'd0;
         rx_cnt_q  <= 16'd0;
         ovf_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         err_q     <= 8'd0;
         wr_rdy_q  <= 1'b1;
         rd_ena_q  <= 1'b0;
         rd_v_q    <= 32'd0;
         rd_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         method_q  <= method_d;
         len_q     <= len_d;
         rx_cnt_q  <= rx_cnt_d;
         ovf_q     <= ovf_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         err_q     <= err_d;
         wr_rdy_q  <= wr_rdy_d;
         rd_ena_q  <= rd_ena_d;
         rd_v_q    <= rd_v_d;
         rd_last_q <= rd_last_d;
      end
   end

   // Payload storage; contents are don't-care after reset.
   always_ff @(posedge CLK) begin
      if (buf_we_s) begin
         buf_q[wptr_q[AW-1:0]] <= write_enq_v;
      end
   end

   assign write_enq__RDY = wr_rdy_q;
   assign read_enq__ENA  = rd_ena_q;
   assign read_enq_v     = rd_v_q;
   assign read_enq_last  = rd_last_q;
   assign errCount       = err_q;

endmodule

// File: tb/tb_portal_echo_user.sv
// Directed bench for portal_echo_user: table of request messages with hand-computed
// echoes, plus stall, error-saturation and mid-message reset sequences.
module tb_portal_echo_user;

   logic        CLK;
   logic        nRST;
   logic        w_ena;
   logic [31:0] w_v;
   logic        w_last;
   logic        w_rdy;
   logic        r_ena;
   logic [31:0] r_v;
   logic        r_last;
   logic        r_rdy;
   logic [7:0]  err_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int err_exp = 0;

   typedef struct {
      string             name;
      logic [31:0]       hdr;
      int                npay;
      logic [9:0][31:0]  pay;
      int                nind;
      logic [8:0][31:0]  ind;
      int                err_inc;
   } vec_t;

   vec_t tbl[6];

   portal_echo_user #(.DEPTH(8)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .write_enq__ENA (w_ena),
      .write_enq_v    (w_v),
      .write_enq_last (w_last),
      .write_enq__RDY (w_rdy),
      .read_enq__ENA  (r_ena),
      .read_enq_v     (r_v),
      .read_enq_last  (r_last),
      .read_enq__RDY  (r_rdy),
      .errCount       (err_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s.%s: got %h, expected %h", nm, tag, got, want);
      end
   endtask

   // Entered and left at a negedge.
   task automatic send_beat(input string nm, input logic [31:0] v, input logic last);
      int g = 0;
      w_ena  = 1'b1;
      w_v    = v;
      w_last = last;
      while (!w_rdy && g < 20) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 20) chk(nm, "wr_rdy_timeout", 32'(g), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic send_msg(input string nm, input logic [31:0] hdr, input int npay, input logic [9:0][31:0] pay);
      send_beat(nm, hdr, (npay == 0));
      for (int i = 0; i < npay; i++) send_beat(nm, pay[i], (i == npay - 1));
      w_ena  = 1'b0;
      w_v    = 32'd0;
      w_last = 1'b0;
   endtask

   task automatic check_ind(input string nm, input int nind, input logic [8:0][31:0] ind);
      int n   = 0;
      int cyc = 0;
      while (n < nind && cyc < 40) begin
         if (r_ena) begin
            chk(nm, "beat", r_v, ind[n]);
            chk(nm, "last", {31'd0, r_last}, {31'd0, (n == nind - 1)});
            chk(nm, "wr_rdy_low", {31'd0, w_rdy}, 32'd0);
            n++;
         end
         @(posedge CLK);
         @(negedge CLK);
         cyc++;
      end
      chk(nm, "beats", 32'(n), 32'(nind));
      chk(nm, "cycles", 32'(cyc), 32'(nind));
      chk(nm, "idle_ena", {31'd0, r_ena}, 32'd0);
      chk(nm, "idle_v", r_v, 32'd0);
   endtask

   task automatic run_vec(input vec_t t);
      send_msg(t.name, t.hdr, t.npay, t.pay);
      check_ind(t.name, t.nind, t.ind);
      err_exp = (err_exp + t.err_inc > 255) ? 255 : err_exp + t.err_inc;
      chk(t.name, "errCount", {24'd0, err_cnt}, 32'(err_exp));
   endtask

   initial begin
      logic [9:0][31:0] pay;
      logic [8:0][31:0] ind;
      for (int k = 0; k < 6; k++) begin
         tbl[k].pay = '0;
         tbl[k].ind = '0;
      end
      tbl[0].name = "two_word"; tbl[0].hdr = 32'h0005_0002; tbl[0].npay = 2;
      tbl[0].pay[0] = 32'h1111_1111; tbl[0].pay[1] = 32'h2222_2222;
      tbl[0].nind = 3; tbl[0].ind[0] = 32'h8005_0002;
      tbl[0].ind[1] = 32'hEEEE_EEEE; tbl[0].ind[2] = 32'hDDDD_DDDD; tbl[0].err_inc = 0;

      tbl[1].name = "hdr_only"; tbl[1].hdr = 32'h0003_0000; tbl[1].npay = 0;
      tbl[1].nind = 1; tbl[1].ind[0] = 32'h8003_0000; tbl[1].err_inc = 0;

      tbl[2].name = "overflow"; tbl[2].hdr = 32'h0001_000A; tbl[2].npay = 10;
      for (int i = 0; i < 10; i++) tbl[2].pay[i] = 32'hA000_0001 + 32'(i);
      tbl[2].nind = 9; tbl[2].ind[0] = 32'h8001_0008;
      tbl[2].ind[1] = 32'h5FFF_FFFE; tbl[2].ind[2] = 32'h5FFF_FFFD;
      tbl[2].ind[3] = 32'h5FFF_FFFC; tbl[2].ind[4] = 32'h5FFF_FFFB;
      tbl[2].ind[5] = 32'h5FFF_FFFA; tbl[2].ind[6] = 32'h5FFF_FFF9;
      tbl[2].ind[7] = 32'h5FFF_FFF8; tbl[2].ind[8] = 32'h5FFF_FFF7; tbl[2].err_inc = 1;

      tbl[3].name = "short"; tbl[3].hdr = 32'h0007_0003; tbl[3].npay = 2;
      tbl[3].pay[0] = 32'h0000_FFFF; tbl[3].pay[1] = 32'h1234_5678;
      tbl[3].nind = 3; tbl[3].ind[0] = 32'h8007_0002;
      tbl[3].ind[1] = 32'hFFFF_0000; tbl[3].ind[2] = 32'hEDCB_A987; tbl[3].err_inc = 1;

      tbl[4].name = "full_exact"; tbl[4].hdr = 32'h0009_0008; tbl[4].npay = 8;
      for (int i = 0; i < 8; i++) tbl[4].pay[i] = 32'h1111_1111 * 32'(i);
      tbl[4].nind = 9; tbl[4].ind[0] = 32'h8009_0008;
      tbl[4].ind[1] = 32'hFFFF_FFFF; tbl[4].ind[2] = 32'hEEEE_EEEE;
      tbl[4].ind[3] = 32'hDDDD_DDDD; tbl[4].ind[4] = 32'hCCCC_CCCC;
      tbl[4].ind[5] = 32'hBBBB_BBBB; tbl[4].ind[6] = 32'hAAAA_AAAA;
      tbl[4].ind[7] = 32'h9999_9999; tbl[4].ind[8] = 32'h8888_8888; tbl[4].err_inc = 0;

      tbl[5].name = "hdr_only_badlen"; tbl[5].hdr = 32'h8002_0002; tbl[5].npay = 0;
      tbl[5].nind = 1; tbl[5].ind[0] = 32'h8002_0000; tbl[5].err_inc = 1;

      nRST = 1'b0; w_ena = 1'b0; w_v = 32'd0; w_last = 1'b0; r_rdy = 1'b1;
      repeat (2) @(negedge CLK);
      chk("reset", "wr_rdy", {31'd0, w_rdy}, 32'd1);
      chk("reset", "rd_ena", {31'd0, r_ena}, 32'd0);
      chk("reset", "rd_v", r_v, 32'd0);
      chk("reset", "rd_last", {31'd0, r_last}, 32'd0);
      chk("reset", "errCount", {24'd0, err_cnt}, 32'd0);
      nRST = 1'b1;

      for (int k = 0; k < 6; k++) run_vec(tbl[k]);

      // Read-side stall for 5 cycles on the first payload beat.
      pay = '0;
      pay[0] = 32'h1; pay[1] = 32'h2; pay[2] = 32'h3; pay[3] = 32'h4;
      send_msg("stall", 32'h000B_0004, 4, pay);
      chk("stall", "hdr", r_v, 32'h800B_0004);
      @(posedge CLK);
      @(negedge CLK);
      r_rdy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge CLK);
         @(negedge CLK);
         chk("stall", "hold_v", r_v, 32'hFFFF_FFFE);
         chk("stall", "hold_ena", {31'd0, r_ena}, 32'd1);
         chk("stall", "hold_wr_rdy", {31'd0, w_rdy}, 32'd0);
      end
      r_rdy = 1'b1;
      ind = '0;
      ind[0] = 32'hFFFF_FFFE; ind[1] = 32'hFFFF_FFFD; ind[2] = 32'hFFFF_FFFC; ind[3] = 32'hFFFF_FFFB;
      check_ind("stall_rel", 4, ind);
      chk("stall", "errCount", {24'd0, err_cnt}, 32'(err_exp));

      // Enough short messages to pin errCount at its ceiling.
      for (int m = 0; m < 256; m++) run_vec(tbl[3]);
      chk("saturate", "errCount", {24'd0, err_cnt}, 32'h0000_00FF);

      // Reset while the second payload beat is on offer.
      pay = '0;
      pay[0] = 32'h10; pay[1] = 32'h20; pay[2] = 32'h30; pay[3] = 32'h40;
      send_msg("midrst", 32'h000C_0004, 4, pay);
      chk("midrst", "hdr", r_v, 32'h800C_0004);
      @(posedge CLK);
      @(negedge CLK);
      chk("midrst", "beat0", r_v, 32'hFFFF_FFEF);
      @(posedge CLK);
      @(negedge CLK);
      chk("midrst", "beat1", r_v, 32'hFFFF_FFDF);
      nRST = 1'b0;
      #1;
      chk("midrst", "rd_ena", {31'd0, r_ena}, 32'd0);
      chk("midrst", "rd_v", r_v, 32'd0);
      chk("midrst", "rd_last", {31'd0, r_last}, 32'd0);
      chk("midrst", "wr_rdy", {31'd0, w_rdy}, 32'd1);
      chk("midrst", "errCount", {24'd0, err_cnt}, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      err_exp = 0;
      run_vec(tbl[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
